// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: 8 lines of 4 words. Hits cost no stall cycles.
// A miss stalls the CPU, reads a 128-bit block from memory and refills the line.
module icache_controller #(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            PC,
    output logic [31:0]            instruction,
    output logic                   busywait,
    output logic                   mem_read,
    output logic [ADDR_BITS-5:0]   mem_address,
    input  logic [127:0]           mem_readdata,
    input  logic                   mem_busywait,
    output logic [CNT_WIDTH-1:0]   miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_BITS - 4 - IDX_W;
    localparam int unsigned MA_W  = ADDR_BITS - 4;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    state_t                 state_q, state_d;
    logic [127:0]           data_q [NUM_LINES];
    logic [127:0]           data_d [NUM_LINES];
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    logic [TAG_W-1:0]       tag_d [NUM_LINES];
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [MA_W-1:0]        miss_addr_q, miss_addr_d;
    logic [127:0]           refill_q, refill_d;
    logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;

    logic [1:0]             pc_off;
    logic [IDX_W-1:0]       pc_idx;
    logic [TAG_W-1:0]       pc_tag;
    logic [IDX_W-1:0]       miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic [127:0]           line;
    logic                   hit;
    logic                   unused_pc;

    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign pc_off   = PC[3:2];
    assign pc_idx   = PC[4 +: IDX_W];
    assign pc_tag   = PC[4 + IDX_W +: TAG_W];
    assign miss_idx = miss_addr_q[IDX_W-1:0];
    assign miss_tag = miss_addr_q[MA_W-1:IDX_W];

    assign line = data_q[pc_idx];
    assign hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    // The indexed word is presented whether or not the access hits.
    always_comb begin
        instruction = line[31:0];
        case (pc_off)
            2'd0: instruction = line[31:0];
            2'd1: instruction = line[63:32];
            2'd2: instruction = line[95:64];
            2'd3: instruction = line[127:96];
            default: instruction = line[31:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        miss_addr_d  = miss_addr_q;
        refill_d     = refill_q;
        miss_count_d = miss_count_q;
        busywait     = 1'b1;
        mem_read     = 1'b0;
        mem_address  = '0;

        case (state_q)
            IDLE: begin
                busywait = !hit;
                if (!hit) begin
                    miss_addr_d = {pc_tag, pc_idx};
                    state_d     = MEM_READ;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = miss_addr_q;
                if (!mem_busywait) begin
                    refill_d = mem_readdata;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                data_d[miss_idx]  = refill_q;
                tag_d[miss_idx]   = miss_tag;
                valid_d[miss_idx] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_addr_q  <= '0;
            refill_q     <= '0;
            miss_count_q <= '0;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_addr_q  <= miss_addr_d;
            refill_q     <= refill_d;
            miss_count_q <= miss_count_d;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: cold miss, hits, eviction, PC change
// during refill, asynchronous reset mid-refill and zero-wait memory.
module tb_icache_controller;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [15:0]  miss_count;

    int checks = 0;
    int errors = 0;
    int stall;

    localparam logic [127:0] BLK_A = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] BLK_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [127:0] BLK_C = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [127:0] BLK_D = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;

    icache_controller #(
        .NUM_LINES(8),
        .ADDR_BITS(10),
        .CNT_WIDTH(16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .instruction (instruction),
        .busywait    (busywait),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait),
        .miss_count  (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Entered at a negedge in IDLE with a missing PC applied; returns in IDLE
    // after the line is written. stall_cycles counts busywait cycles after the miss edge.
    task automatic refill(input logic [127:0] blk, input int busy, input logic [5:0] addr,
                          output int stall_cycles);
        stall_cycles = 0;
        mem_readdata = blk;
        mem_busywait = (busy > 0);
        #1 chk("miss_detect", busywait, 1'b1);
        step();
        for (int i = 0; i < busy; i++) begin
            #1 chk("wait_mem_read", mem_read, 1'b1);
            chk("wait_mem_address", mem_address, addr);
            if (busywait) stall_cycles++;
            step();
        end
        mem_busywait = 1'b0;
        #1 chk("last_mem_read", mem_read, 1'b1);
        chk("last_mem_address", mem_address, addr);
        if (busywait) stall_cycles++;
        step();
        mem_busywait = 1'b1;
        #1 chk("update_mem_read", mem_read, 1'b0);
        chk("update_busywait", busywait, 1'b1);
        if (busywait) stall_cycles++;
        step();
        mem_busywait = 1'b0;
        mem_readdata = '0;
    endtask

    initial begin
        RESET        = 1'b1;
        PC           = 32'h000;
        mem_readdata = '0;
        mem_busywait = 1'b0;
        @(negedge CLK);
        #1 chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_address", mem_address, 6'h00);
        chk("rst_miss_count", miss_count, 16'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_busywait", busywait, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;

        // Cold miss with 5 busy cycles
        refill(BLK_A, 5, 6'h00, stall);
        #1 chk("cold_busywait", busywait, 1'b0);
        chk("cold_instruction", instruction, 32'h00000001);
        chk("cold_miss_count", miss_count, 16'd1);
        chk("cold_stall", stall, 7);

        // Hits on consecutive cycles, with a mem_busywait glitch in IDLE
        PC = 32'h004; mem_busywait = 1'b1;
        #1 chk("hit4_busywait", busywait, 1'b0);
        chk("hit4_instruction", instruction, 32'h00000002);
        step();
        PC = 32'h008; mem_busywait = 1'b0;
        #1 chk("hit8_busywait", busywait, 1'b0);
        chk("hit8_instruction", instruction, 32'h00000003);
        chk("hit8_mem_read", mem_read, 1'b0);
        step();
        PC = 32'h00C;
        #1 chk("hitC_busywait", busywait, 1'b0);
        chk("hitC_instruction", instruction, 32'h00000004);
        step();
        #1 chk("hits_miss_count", miss_count, 16'd1);

        // Conflict eviction on index 0
        PC = 32'h080;
        refill(BLK_B, 2, 6'h08, stall);
        #1 chk("evict_busywait", busywait, 1'b0);
        chk("evict_instruction", instruction, 32'hBBBB0000);
        chk("evict_miss_count", miss_count, 16'd2);
        PC = 32'h00C;
        refill(BLK_A, 1, 6'h00, stall);
        #1 chk("reload_instruction", instruction, 32'h00000004);
        chk("reload_miss_count", miss_count, 16'd3);
        step();

        // PC change during MEM_READ is ignored
        PC = 32'h010; mem_busywait = 1'b1; mem_readdata = BLK_C;
        #1 chk("pcchg_miss", busywait, 1'b1);
        step();
        PC = 32'h020;
        #1 chk("pcchg_mem_read", mem_read, 1'b1);
        chk("pcchg_addr0", mem_address, 6'h01);
        step();
        #1 chk("pcchg_addr1", mem_address, 6'h01);
        mem_busywait = 1'b0;
        step();
        mem_readdata = '0;
        #1 chk("pcchg_update_busywait", busywait, 1'b1);
        step();
        #1 chk("pcchg_new_miss", busywait, 1'b1);
        chk("pcchg_miss_count", miss_count, 16'd4);
        refill(BLK_D, 1, 6'h02, stall);
        #1 chk("pcchg_instr_d", instruction, 32'hDDDD0000);
        chk("pcchg_miss_count2", miss_count, 16'd5);
        PC = 32'h018;
        #1 chk("pcchg_hit_c", busywait, 1'b0);
        chk("pcchg_instr_c", instruction, 32'hCCCC0002);
        step();

        // Asynchronous reset during MEM_READ
        PC = 32'h030; mem_busywait = 1'b1;
        step();
        #1 chk("rstmid_mem_read_before", mem_read, 1'b1);
        #2 RESET = 1'b1;
        #1 chk("rstmid_mem_read", mem_read, 1'b0);
        chk("rstmid_mem_address", mem_address, 6'h00);
        chk("rstmid_miss_count", miss_count, 16'd0);
        chk("rstmid_busywait", busywait, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        PC = 32'h010; mem_busywait = 1'b0;
        #1 chk("rstmid_line1_invalid", busywait, 1'b1);
        chk("rstmid_instruction", instruction, 32'h0);
        chk("rstmid_count_before", miss_count, 16'd0);

        // Zero-wait memory refill
        refill(BLK_C, 0, 6'h01, stall);
        #1 chk("zw_stall", stall, 2);
        chk("zw_busywait", busywait, 1'b0);
        chk("zw_instruction", instruction, 32'hCCCC0000);
        chk("zw_miss_count", miss_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
